multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Five-phase (IF/ID/EXE/MEM/WB) control state machine for the multicycle CPU. Decodes the 6-bit opcode and ALU zero flag into the per-cycle datapath enables and mux selects. Its `PCSrc` output is the 2-bit select driving the datapath's 32-bit 4-to-1 next-PC selector. It is that selector's direct upstream stage.

## Interface
- `OPCODE_W`, default 6: opcode width.
- `ALUOP_W`, default 3: ALU operation code width.
- `CLK  in  1`: sole clock, rising edge.
- `Reset  in  1`: asynchronous, active-low; 0 forces state to sIF.
- `op  in  6`: opcode `IR[31:26]`, held stable by IR from sID onward.
- `zero  in  1`: ALU zero flag, sampled in sEXE_BR.
- `state  out  3`: current state encoding, for debug.
- `PCWre  out  1`: PC load enable.
- `IRWre  out  1`: IR load enable.
- `InsMemRW  out  1`: instruction memory read enable.
- `ExtSel  out  1`: sign-extend when 1, else zero-extend.
- `ALUSrcA  out  1`: 1 selects shamt, 0 selects rs.
- `ALUSrcB  out  1`: 1 selects extended immediate, 0 selects rt.
- `ALUOp  out  3`: ALU function.
- `RegDst  out  2`: 00 = $31, 01 = rt, 10 = rd.
- `WrRegDSrc  out  1`: 0 writes PC+4 (jal), 1 writes DB.
- `DBDataSrc  out  1`: 0 selects ALU result, 1 selects memory data.
- `RegWre  out  1`: register file write enable.
- `mRD  out  1`: data memory read.
- `mWR  out  1`: data memory write.
- `PCSrc  out  2`: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = {PC[31:28], addr, 2'b00}.

## Operation
- **States** (3-bit): sIF=000, sID=001, sEXE_LS=010, sMEM=011, sWB_L=100, sEXE_BR=101, sEXE_AL=110, sWB_AL=111.
- **Opcodes**: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
- **Transitions**:
  - sIF → sID always.
  - From sID:
    - j / jr / jal → sIF.
    - beq / bne → sEXE_BR.
    - lw / sw → sEXE_LS.
    - halt → sID (held until reset).
    - ALU ops → sEXE_AL.
    - Undefined opcode → sIF, executed as a nop.
  - sEXE_AL → sWB_AL → sIF.
  - sEXE_BR → sIF.
  - sEXE_LS → sMEM.
  - From sMEM: sw → sIF; lw → sWB_L.
  - sWB_L → sIF.
- **Output decode**: combinational from (state, op, zero). Every output not listed for a state is 0.
- **PCWre**: 1 only in the terminating cycle of an instruction, i.e. whenever next state is sIF. This covers undefined opcodes in sID. It is never 1 for halt.
- **PCSrc**: meaningful only while PCWre=1.
  - j → 11; jr → 10; jal → 11.
  - beq → 01 iff zero=1; bne → 01 iff zero=0; otherwise 00.
  - All other instructions → 00.
- **Per-state asserts**:
  - sIF: InsMemRW=1, IRWre=1.
  - sID, jal: RegWre=1, RegDst=00, WrRegDSrc=0.
  - ExtSel: 1 for addi, lw, sw, beq, bne; 0 for ori.
  - ALUSrcA=1 for sll only.
  - ALUSrcB=1 for addi, ori, lw, sw.
  - ALUOp: add 000, sub 001, or 011, and 100, sll 010, slt 110, addi/lw/sw 000, ori 011, beq/bne 001. Held constant from sID through the instruction's last state.
  - sWB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=01 for addi/ori, else 10.
  - sMEM: lw mRD=1, sw mWR=1.
  - sWB_L: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1; mRD stays 1.

## Timing
- **Reset**: asynchronous assert, synchronous-release behaviour. state=sIF during and after reset.
  - Outputs while in reset: IRWre=1, InsMemRW=1, all others 0, PCSrc=00.
- **Reset mid-instruction**: aborts immediately. No RegWre or mWR is asserted after the asserting edge.
- **Cycles per instruction**:
  - j / jr / jal / undefined: 2.
  - beq / bne: 3.
  - ALU ops and sw: 4.
  - lw: 5.
  - halt: unbounded.
- **zero**: used only in sEXE_BR, same cycle (combinational path to PCSrc).

## Structure
- Shared package `mcpu_ctrl_pkg` holds:
  - opcode localparams;
  - state encodings;
  - PCSrc and RegDst encodings;
  - ALUOp codes.
- State register and next-state logic live in this module.
- Output decode goes in one combinational sub-module, `control_signal_decoder` (inputs state, op, zero).

## Test plan
- Reset low mid-sEXE_AL → state=000, RegWre=0, PCWre=0 within the same cycle. After release, the first edge moves state to sID.
- add (op 000000) → states 000,001,110,111,000. RegWre=1 only in 111, with RegDst=10. PCWre=1 only in 111, with PCSrc=00.
- lw then sw → lw walks 000,001,010,011,100 with mRD=1 in 011/100 and DBDataSrc=1 in 100. sw walks 000,001,010,011 with mWR=1 in 011 and PCWre=1 there.
- beq with zero=1 → in sEXE_BR PCSrc=01, PCWre=1. Repeat with zero=0 → PCSrc=00. bne gives the inverse.
- jal → 2 cycles. In sID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. jr → PCSrc=10.
- halt (111111) → stuck in sID with PCWre=0 for 20 cycles. Undefined op 101010 → returns to sIF after 2 cycles with PCSrc=00.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: opcodes, FSM states,
// PCSrc/RegDst selects, ALU function codes and an opcode classifier.
package mcpu_ctrl_pkg;

  localparam int OPCODE_BITS = 6;
  localparam int ALUOP_BITS  = 3;

  localparam logic [5:0] op_add  = 6'b000000;
  localparam logic [5:0] op_sub  = 6'b000001;
  localparam logic [5:0] op_addi = 6'b000010;
  localparam logic [5:0] op_or   = 6'b010000;
  localparam logic [5:0] op_and  = 6'b010001;
  localparam logic [5:0] op_ori  = 6'b010010;
  localparam logic [5:0] op_sll  = 6'b011000;
  localparam logic [5:0] op_slt  = 6'b100110;
  localparam logic [5:0] op_sw   = 6'b110000;
  localparam logic [5:0] op_lw   = 6'b110001;
  localparam logic [5:0] op_beq  = 6'b110100;
  localparam logic [5:0] op_bne  = 6'b110101;
  localparam logic [5:0] op_j    = 6'b111000;
  localparam logic [5:0] op_jr   = 6'b111001;
  localparam logic [5:0] op_jal  = 6'b111010;
  localparam logic [5:0] op_halt = 6'b111111;

  typedef enum logic [2:0] {
    s_if     = 3'b000,
    s_id     = 3'b001,
    s_exe_ls = 3'b010,
    s_mem    = 3'b011,
    s_wb_l   = 3'b100,
    s_exe_br = 3'b101,
    s_exe_al = 3'b110,
    s_wb_al  = 3'b111
  } state_t;

  localparam logic [1:0] pc_plus4  = 2'b00;
  localparam logic [1:0] pc_branch = 2'b01;
  localparam logic [1:0] pc_rs     = 2'b10;
  localparam logic [1:0] pc_jump   = 2'b11;

  localparam logic [1:0] rd_ra = 2'b00;
  localparam logic [1:0] rd_rt = 2'b01;
  localparam logic [1:0] rd_rd = 2'b10;

  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sub = 3'b001;
  localparam logic [2:0] alu_sll = 3'b010;
  localparam logic [2:0] alu_or  = 3'b011;
  localparam logic [2:0] alu_and = 3'b100;
  localparam logic [2:0] alu_slt = 3'b110;

  typedef enum logic [2:0] {
    cls_alu, cls_ls, cls_br, cls_jmp, cls_halt, cls_undef
  } op_class_t;

  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      op_add, op_sub, op_addi, op_or, op_and, op_ori, op_sll, op_slt: return cls_alu;
      op_sw, op_lw:         return cls_ls;
      op_beq, op_bne:       return cls_br;
      op_j, op_jr, op_jal:  return cls_jmp;
      op_halt:              return cls_halt;
      default:              return cls_undef;
    endcase
  endfunction

  function automatic logic [2:0] alu_op(input logic [5:0] op);
    case (op)
      op_sub, op_beq, op_bne: return alu_sub;
      op_or, op_ori:          return alu_or;
      op_and:                 return alu_and;
      op_sll:                 return alu_sll;
      op_slt:                 return alu_slt;
      default:                return alu_add;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
// Plain level signals, no valid/ready: the datapath consumes every field each cycle.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] op;
  logic                zero;
  logic                PCWre;
  logic                IRWre;
  logic                InsMemRW;
  logic                ExtSel;
  logic                ALUSrcA;
  logic                ALUSrcB;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [1:0]          RegDst;
  logic                WrRegDSrc;
  logic                DBDataSrc;
  logic                RegWre;
  logic                mRD;
  logic                mWR;
  logic [1:0]          PCSrc;

  modport master (
    input  op, zero,
    output PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, PCSrc
  );

  modport slave (
    output op, zero,
    input  PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, PCSrc
  );
endinterface

// File: rtl/control_signal_decoder.sv
// Purely combinational decode of (state, op, zero) into datapath controls.
// PCWre marks the cycle whose successor state is sIF.
module control_signal_decoder
  import mcpu_ctrl_pkg::*;
(
  input  state_t                  state,
  input  logic [OPCODE_BITS-1:0]  op,
  input  logic                    zero,
  output logic                    PCWre,
  output logic                    IRWre,
  output logic                    InsMemRW,
  output logic                    ExtSel,
  output logic                    ALUSrcA,
  output logic                    ALUSrcB,
  output logic [ALUOP_BITS-1:0]   ALUOp,
  output logic [1:0]              RegDst,
  output logic                    WrRegDSrc,
  output logic                    DBDataSrc,
  output logic                    RegWre,
  output logic                    mRD,
  output logic                    mWR,
  output logic [1:0]              PCSrc
);

  op_class_t cls;
  assign cls = op_class(op);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = alu_add;
    RegDst    = rd_ra;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = pc_plus4;

    // Operand selects stay stable from decode to the last cycle of the instruction.
    if (state != s_if) begin
      ALUOp   = alu_op(op);
      ExtSel  = (op == op_addi) || (op == op_lw) || (op == op_sw) ||
                (op == op_beq)  || (op == op_bne);
      ALUSrcA = (op == op_sll);
      ALUSrcB = (op == op_addi) || (op == op_ori) || (op == op_lw) || (op == op_sw);
    end

    case (state)
      s_if: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
      end
      s_id: begin
        if (cls == cls_jmp || cls == cls_undef) PCWre = 1'b1;
        if (op == op_j || op == op_jal) PCSrc = pc_jump;
        if (op == op_jr)                PCSrc = pc_rs;
        if (op == op_jal)               RegWre = 1'b1;
      end
      s_exe_br: begin
        PCWre = 1'b1;
        if ((op == op_beq && zero) || (op == op_bne && !zero)) PCSrc = pc_branch;
      end
      s_mem: begin
        mRD   = (op == op_lw);
        mWR   = (op == op_sw);
        PCWre = (op != op_lw);
      end
      s_wb_l: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = rd_rt;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        mRD       = 1'b1;
      end
      s_wb_al: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = (op == op_addi || op == op_ori) ? rd_rt : rd_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-phase control FSM for the multicycle CPU; holds the state register and
// next-state logic, output decode lives in control_signal_decoder.
module multicycle_control_unit
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                        CLK,
  input  logic                        Reset,
  multicycle_control_unit_if.master   bus,
  output logic [2:0]                  state
);

  state_t              state_q;
  state_t              state_d;
  op_class_t           cls;
  logic [OPCODE_W-1:0] op_w;
  logic [ALUOP_W-1:0]  aluop_w;

  assign op_w  = bus.op;
  assign cls   = op_class(op_w);
  assign state = state_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= s_if;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = s_if;
    case (state_q)
      s_if: state_d = s_id;
      s_id: begin
        case (cls)
          cls_alu:  state_d = s_exe_al;
          cls_ls:   state_d = s_exe_ls;
          cls_br:   state_d = s_exe_br;
          cls_halt: state_d = s_id;
          default:  state_d = s_if;
        endcase
      end
      s_exe_al: state_d = s_wb_al;
      s_exe_ls: state_d = s_mem;
      s_mem:    state_d = (op_w == op_lw) ? s_wb_l : s_if;
      default:  state_d = s_if;
    endcase
  end

  control_signal_decoder u_decoder (
    .state     (state_q),
    .op        (op_w),
    .zero      (bus.zero),
    .PCWre     (bus.PCWre),
    .IRWre     (bus.IRWre),
    .InsMemRW  (bus.InsMemRW),
    .ExtSel    (bus.ExtSel),
    .ALUSrcA   (bus.ALUSrcA),
    .ALUSrcB   (bus.ALUSrcB),
    .ALUOp     (aluop_w),
    .RegDst    (bus.RegDst),
    .WrRegDSrc (bus.WrRegDSrc),
    .DBDataSrc (bus.DBDataSrc),
    .RegWre    (bus.RegWre),
    .mRD       (bus.mRD),
    .mWR       (bus.mWR),
    .PCSrc     (bus.PCSrc)
  );

  assign bus.ALUOp = aluop_w;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expected control words
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;

  multicycle_control_unit_if bus ();

  multicycle_control_unit dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  // Word layout: state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB,
  // ALUOp, RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, PCSrc
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [20:0] ifv;
  logic [20:0] act;

  assign act = {state, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ExtSel, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.RegDst, bus.WrRegDSrc, bus.DBDataSrc,
                bus.RegWre, bus.mRD, bus.mWR, bus.PCSrc};

  function automatic logic [20:0] v(input int st, input int pcw, input int irw, input int imr,
                                    input int ext, input int sa, input int sb, input int aop,
                                    input int rd, input int wrs, input int dbs, input int rw,
                                    input int mrd, input int mwr, input int pcs);
    return {st[2:0], pcw[0], irw[0], imr[0], ext[0], sa[0], sb[0], aop[2:0], rd[1:0],
            wrs[0], dbs[0], rw[0], mrd[0], mwr[0], pcs[1:0]};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [20:0] mon_e;
  string       mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        failures++;
        $display("FAIL %s actual=%b required=%b", mon_n, act, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input string nm, input logic [20:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int o, input int z);
    bus.op   = o[5:0];
    bus.zero = z[0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifv   = v(0, 0,1,1, 0,0,0, 0, 0, 0,0,0, 0,0, 0);
    rst_n = 1'b0;
    set_op(6'b000000, 0);
    @(posedge clk);
    #1;
    cyc("reset_hold", ifv);
    rst_n = 1'b1;

    // add
    cyc("add_if",  ifv);
    cyc("add_id",  v(1, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    cyc("add_exe", v(6, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    set_op(6'b000000, 1);
    cyc("add_wb",  v(7, 1,0,0, 0,0,0, 0, 2, 1,0,1, 0,0, 0));

    set_op(6'b000001, 0);
    cyc("sub_if",  ifv);
    cyc("sub_id",  v(1, 0,0,0, 0,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("sub_exe", v(6, 0,0,0, 0,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("sub_wb",  v(7, 1,0,0, 0,0,0, 1, 2, 1,0,1, 0,0, 0));

    set_op(6'b000010, 0);
    cyc("addi_if",  ifv);
    cyc("addi_id",  v(1, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("addi_exe", v(6, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("addi_wb",  v(7, 1,0,0, 1,0,1, 0, 1, 1,0,1, 0,0, 0));

    set_op(6'b010010, 0);
    cyc("ori_if",  ifv);
    cyc("ori_id",  v(1, 0,0,0, 0,0,1, 3, 0, 0,0,0, 0,0, 0));
    cyc("ori_exe", v(6, 0,0,0, 0,0,1, 3, 0, 0,0,0, 0,0, 0));
    cyc("ori_wb",  v(7, 1,0,0, 0,0,1, 3, 1, 1,0,1, 0,0, 0));

    set_op(6'b011000, 0);
    cyc("sll_if",  ifv);
    cyc("sll_id",  v(1, 0,0,0, 0,1,0, 2, 0, 0,0,0, 0,0, 0));
    cyc("sll_exe", v(6, 0,0,0, 0,1,0, 2, 0, 0,0,0, 0,0, 0));
    cyc("sll_wb",  v(7, 1,0,0, 0,1,0, 2, 2, 1,0,1, 0,0, 0));

    set_op(6'b100110, 0);
    cyc("slt_if",  ifv);
    cyc("slt_id",  v(1, 0,0,0, 0,0,0, 6, 0, 0,0,0, 0,0, 0));
    cyc("slt_exe", v(6, 0,0,0, 0,0,0, 6, 0, 0,0,0, 0,0, 0));
    cyc("slt_wb",  v(7, 1,0,0, 0,0,0, 6, 2, 1,0,1, 0,0, 0));

    set_op(6'b010001, 0);
    cyc("and_if",  ifv);
    cyc("and_id",  v(1, 0,0,0, 0,0,0, 4, 0, 0,0,0, 0,0, 0));
    cyc("and_exe", v(6, 0,0,0, 0,0,0, 4, 0, 0,0,0, 0,0, 0));
    cyc("and_wb",  v(7, 1,0,0, 0,0,0, 4, 2, 1,0,1, 0,0, 0));

    set_op(6'b110001, 0);
    cyc("lw_if",  ifv);
    cyc("lw_id",  v(1, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("lw_exe", v(2, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("lw_mem", v(3, 0,0,0, 1,0,1, 0, 0, 0,0,0, 1,0, 0));
    cyc("lw_wb",  v(4, 1,0,0, 1,0,1, 0, 1, 1,1,1, 1,0, 0));

    set_op(6'b110000, 0);
    cyc("sw_if",  ifv);
    cyc("sw_id",  v(1, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("sw_exe", v(2, 0,0,0, 1,0,1, 0, 0, 0,0,0, 0,0, 0));
    cyc("sw_mem", v(3, 1,0,0, 1,0,1, 0, 0, 0,0,0, 0,1, 0));

    set_op(6'b110100, 1);
    cyc("beq_z1_if", ifv);
    cyc("beq_z1_id", v(1, 0,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("beq_z1_br", v(5, 1,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 1));
    set_op(6'b110100, 0);
    cyc("beq_z0_if", ifv);
    cyc("beq_z0_id", v(1, 0,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("beq_z0_br", v(5, 1,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));
    set_op(6'b110101, 0);
    cyc("bne_z0_if", ifv);
    cyc("bne_z0_id", v(1, 0,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("bne_z0_br", v(5, 1,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 1));
    set_op(6'b110101, 1);
    cyc("bne_z1_if", ifv);
    cyc("bne_z1_id", v(1, 0,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));
    cyc("bne_z1_br", v(5, 1,0,0, 1,0,0, 1, 0, 0,0,0, 0,0, 0));

    set_op(6'b111010, 0);
    cyc("jal_if", ifv);
    cyc("jal_id", v(1, 1,0,0, 0,0,0, 0, 0, 0,0,1, 0,0, 3));
    set_op(6'b111001, 0);
    cyc("jr_if",  ifv);
    cyc("jr_id",  v(1, 1,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 2));
    set_op(6'b111000, 0);
    cyc("j_if",   ifv);
    cyc("j_id",   v(1, 1,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 3));
    set_op(6'b101010, 0);
    cyc("undef_if", ifv);
    cyc("undef_id", v(1, 1,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));

    // reset asserted on entry to sEXE_AL: must abort before the write-back cycle
    set_op(6'b000000, 0);
    cyc("abort_if", ifv);
    cyc("abort_id", v(1, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    rst_n = 1'b0;
    cyc("abort_rst",  ifv);
    cyc("abort_hold", ifv);
    rst_n = 1'b1;
    cyc("abort_rel_if", ifv);
    cyc("abort_rel_id", v(1, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    cyc("abort_rel_exe", v(6, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    cyc("abort_rel_wb", v(7, 1,0,0, 0,0,0, 0, 2, 1,0,1, 0,0, 0));

    set_op(6'b111111, 0);
    cyc("halt_if", ifv);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("halt_id%0d", i), v(1, 0,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 0));
    rst_n = 1'b0;
    cyc("halt_rst", ifv);
    rst_n = 1'b1;
    set_op(6'b111000, 0);
    cyc("post_halt_if", ifv);
    cyc("post_halt_id", v(1, 1,0,0, 0,0,0, 0, 0, 0,0,0, 0,0, 3));
    cyc("post_halt_if2", ifv);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
